conv2x2_seq_ctrl: RTL and testbench

- Sequencer that drives the 2x2-convolution datapath top: feature/weight buffer ALUs, the four 8-bit 1:4 demuxes and the four output accumulators (c11, c12, c21, c22).
- Issues reads to the shared weight/feature memory, whose data goes straight to the datapath data_in. Raises weight_en/feature_en one-hot, aligned to the read data.
- Steers products with sel_demux and pulses acc_en once per output position.
- Fixed geometry: 3x3 feature map, 2x2 kernel, 2x2 output. Start/busy/done handshake toward the top-level FSM.

---
 rtl/conv_ctrl_pkg.sv | 33 +++
 rtl/conv_ctrl_delay_line.sv | 30 +++
 rtl/conv2x2_seq_ctrl.sv | 130 +++++++++++++
 tb/tb_conv2x2_seq_ctrl.sv | 315 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/conv_ctrl_pkg.sv
// Shared types and fixed geometry for the 2x2 convolution sequencer.
package conv_ctrl_pkg;
  typedef enum logic [2:0] {
    S_IDLE, S_LD_W, S_WAIT_W, S_LD_F, S_WAIT_F, S_ACC, S_DONE
  } state_e;

  typedef enum logic {KIND_W = 1'b0, KIND_F = 1'b1} kind_e;

  localparam logic [1:0] P_C11 = 2'd0;
  localparam logic [1:0] P_C12 = 2'd1;
  localparam logic [1:0] P_C21 = 2'd2;
  localparam logic [1:0] P_C22 = 2'd3;

  localparam int IMG_W  = 3;
  localparam int K_W    = 2;
  localparam int N_TAPS = 4;

  typedef struct packed {
    logic       vld;
    kind_e      kind;
    logic [1:0] k;
  } tap_t;

  // ALU and accumulator vectors put index 0 on the MSB.
  function automatic logic [3:0] onehot_msb(input logic [1:0] idx);
    return 4'b1000 >> idx;
  endfunction

  // Row-major offset of kernel tap k for output position p.
  function automatic int feat_off(input logic [1:0] p, input logic [1:0] k);
    return (int'(p) / K_W + int'(k) / K_W) * IMG_W + int'(p) % K_W + int'(k) % K_W;
  endfunction
endpackage

// File: rtl/conv_ctrl_delay_line.sv
// MEM_LAT-deep tag pipe that realigns buffer enables with memory read data.
module conv_ctrl_delay_line
  import conv_ctrl_pkg::*;
#(
  parameter int MEM_LAT = 1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       push_vld_i,
  input  logic       push_kind_i,
  input  logic [1:0] push_k_i,
  output logic       out_vld_o,
  output logic       out_kind_o,
  output logic [1:0] out_k_o
);
  tap_t [MEM_LAT-1:0] pipe_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      pipe_q <= '0;
    end else begin
      pipe_q[0] <= {push_vld_i, push_kind_i, push_k_i};
      for (int i = 1; i < MEM_LAT; i++) pipe_q[i] <= pipe_q[i-1];
    end
  end

  assign out_vld_o  = pipe_q[MEM_LAT-1].vld;
  assign out_kind_o = pipe_q[MEM_LAT-1].kind;
  assign out_k_o    = pipe_q[MEM_LAT-1].k;
endmodule

// File: rtl/conv2x2_seq_ctrl.sv
// Sequencer for the 2x2 convolution datapath: weight load, then four
// feature-load/accumulate passes, one per output position.
module conv2x2_seq_ctrl
  import conv_ctrl_pkg::*;
#(
  parameter int ADDR_W       = 8,
  parameter int WEIGHT_BASE  = 0,
  parameter int FEATURE_BASE = 4,
  parameter int MEM_LAT      = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  output logic              busy,
  output logic              done,
  output logic              mem_rd_en,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [3:0]        weight_en,
  output logic [3:0]        feature_en,
  output logic [7:0]        sel_demux,
  output logic [3:0]        acc_en
);
  localparam int CNT_W = $clog2(MEM_LAT) + 2;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [1:0]       p_q, p_d;
  logic [1:0]       tap;
  logic             push_vld;
  kind_e            push_kind;
  logic             dl_vld, dl_kind;
  logic [1:0]       dl_k;

  assign tap = cnt_q[1:0];

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      p_q     <= P_C11;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      p_q     <= p_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    p_d       = p_q;
    mem_rd_en = 1'b0;
    mem_addr  = '0;
    push_vld  = 1'b0;
    push_kind = KIND_W;
    acc_en    = 4'b0;
    sel_demux = 8'h00;
    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d = S_LD_W;
          cnt_d   = '0;
          p_d     = P_C11;
        end
      end
      S_LD_W: begin
        mem_rd_en = 1'b1;
        mem_addr  = ADDR_W'(WEIGHT_BASE) + ADDR_W'(tap);
        push_vld  = 1'b1;
        if (cnt_q == CNT_W'(N_TAPS - 1)) begin
          state_d = S_WAIT_W;
          cnt_d   = '0;
        end else cnt_d = cnt_q + CNT_W'(1);
      end
      S_WAIT_W: begin
        if (cnt_q == CNT_W'(MEM_LAT - 1)) begin
          state_d = S_LD_F;
          cnt_d   = '0;
          p_d     = P_C11;
        end else cnt_d = cnt_q + CNT_W'(1);
      end
      S_LD_F: begin
        sel_demux = {4{p_q}};
        mem_rd_en = 1'b1;
        mem_addr  = ADDR_W'(FEATURE_BASE + feat_off(p_q, tap));
        push_vld  = 1'b1;
        push_kind = KIND_F;
        if (cnt_q == CNT_W'(N_TAPS - 1)) begin
          state_d = S_WAIT_F;
          cnt_d   = '0;
        end else cnt_d = cnt_q + CNT_W'(1);
      end
      S_WAIT_F: begin
        sel_demux = {4{p_q}};
        if (cnt_q == CNT_W'(MEM_LAT - 1)) begin
          state_d = S_ACC;
          cnt_d   = '0;
        end else cnt_d = cnt_q + CNT_W'(1);
      end
      // sel_demux still holds p here, so the pulse sees settled products.
      S_ACC: begin
        sel_demux = {4{p_q}};
        acc_en    = onehot_msb(p_q);
        if (p_q == P_C22) state_d = S_DONE;
        else begin
          state_d = S_LD_F;
          p_d     = p_q + 2'd1;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  conv_ctrl_delay_line #(.MEM_LAT(MEM_LAT)) u_dly (
    .clk        (clk),
    .rst        (rst),
    .push_vld_i (push_vld),
    .push_kind_i(push_kind),
    .push_k_i   (tap),
    .out_vld_o  (dl_vld),
    .out_kind_o (dl_kind),
    .out_k_o    (dl_k)
  );

  assign weight_en  = (dl_vld && dl_kind == KIND_W) ? onehot_msb(dl_k) : 4'b0;
  assign feature_en = (dl_vld && dl_kind == KIND_F) ? onehot_msb(dl_k) : 4'b0;
  assign busy       = (state_q != S_IDLE);
  assign done       = (state_q == S_DONE);
endmodule

// File: tb/tb_conv2x2_seq_ctrl.sv
// Bench: two sequencers (MEM_LAT 1 and 2) driven together, each feeding a
// behavioural memory + datapath; traces checked against a schedule model.
module tb_conv2x2_seq_ctrl;
  localparam int NC = 128;

  typedef struct packed {
    logic       rd;
    logic [7:0] addr;
    logic [3:0] we, fe, acc;
    logic [7:0] sel;
    logic       busy, done;
  } ob_t;

  typedef struct {
    int         cyc;
    logic       rd;
    logic [7:0] addr;
    logic [3:0] we, acc;
    logic [7:0] sel;
    logic       busy, done;
  } vec_t;

  logic       clk, rst, start;
  logic       busy_s[2], done_s[2], rd_s[2];
  logic [7:0] addr_s[2], sel_s[2];
  logic [3:0] we_s[2], fe_s[2], acc_s[2];

  logic [7:0]  mem [256];
  logic [7:0]  d0_q, d1a_q, d1b_q;
  logic [7:0]  rdata[2];
  logic [7:0]  wr[2][4], fr[2][4];
  logic [31:0] cacc[2][4];

  ob_t        obs[2][NC], expv[2][NC];
  logic       start_pat[NC], rst_pat[NC];
  logic [31:0] cdone[2][4];
  int         done_cnt[2];
  int         n_chk, n_pass;
  vec_t       tbl[$];

  conv2x2_seq_ctrl #(.MEM_LAT(1)) dut (
    .clk(clk), .rst(rst), .start(start), .busy(busy_s[0]), .done(done_s[0]),
    .mem_rd_en(rd_s[0]), .mem_addr(addr_s[0]), .weight_en(we_s[0]),
    .feature_en(fe_s[0]), .sel_demux(sel_s[0]), .acc_en(acc_s[0]));

  conv2x2_seq_ctrl #(.MEM_LAT(2)) dut2 (
    .clk(clk), .rst(rst), .start(start), .busy(busy_s[1]), .done(done_s[1]),
    .mem_rd_en(rd_s[1]), .mem_addr(addr_s[1]), .weight_en(we_s[1]),
    .feature_en(fe_s[1]), .sel_demux(sel_s[1]), .acc_en(acc_s[1]));

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Memory with 1- and 2-cycle read latency.
  always @(posedge clk) begin
    d0_q  <= mem[addr_s[0]];
    d1a_q <= mem[addr_s[1]];
    d1b_q <= d1a_q;
  end
  assign rdata[0] = d0_q;
  assign rdata[1] = d1b_q;

  function automatic logic [31:0] psum(int i, int q);
    logic [31:0] s = 0;
    for (int a = 0; a < 4; a++)
      if (int'(sel_s[i][7-2*a -: 2]) == q) s += 32'(wr[i][a]) * 32'(fr[i][a]);
    return s;
  endfunction

  // Datapath: ALU buffers, demux routing, accumulators.
  always @(posedge clk) begin
    for (int i = 0; i < 2; i++) begin
      for (int k = 0; k < 4; k++) begin
        if (we_s[i][3-k]) wr[i][k] <= rdata[i];
        if (fe_s[i][3-k]) fr[i][k] <= rdata[i];
      end
      for (int q = 0; q < 4; q++) begin
        if (rst || (start && !busy_s[i])) cacc[i][q] <= 0;
        else if (acc_s[i][3-q]) cacc[i][q] <= cacc[i][q] + psum(i, q);
      end
    end
  end

  task automatic chk(string nm, logic [31:0] act, logic [31:0] req);
    n_chk++;
    if (act === req) n_pass++;
    else $display("FAIL %s: got %h expected %h", nm, act, req);
  endtask

  function automatic ob_t sample(int i);
    ob_t o;
    o.rd   = rd_s[i];
    o.addr = rd_s[i] ? addr_s[i] : 8'h00;
    o.we   = we_s[i];
    o.fe   = fe_s[i];
    o.acc  = acc_s[i];
    o.sel  = sel_s[i];
    o.busy = busy_s[i];
    o.done = done_s[i];
    return o;
  endfunction

  task automatic clear_pats();
    for (int t = 0; t < NC; t++) begin
      start_pat[t] = 1'b0;
      rst_pat[t]   = 1'b0;
    end
    done_cnt[0] = 0;
    done_cnt[1] = 0;
  endtask

  // Cycle t: sample outputs at the falling edge, then drive inputs for t.
  task automatic run(int n);
    for (int t = 0; t < n; t++) begin
      @(negedge clk);
      for (int i = 0; i < 2; i++) begin
        obs[i][t] = sample(i);
        chk("en_onehot", 32'($countones(we_s[i] | fe_s[i]) <= 1), 32'd1);
        chk("acc_vs_en", 32'(acc_s[i] & (we_s[i] | fe_s[i])), 32'd0);
        if (done_s[i]) begin
          done_cnt[i]++;
          for (int q = 0; q < 4; q++) cdone[i][q] = cacc[i][q];
        end
      end
      start = start_pat[t];
      rst   = rst_pat[t];
    end
  endtask

  task automatic do_reset();
    clear_pats();
    rst_pat[0] = 1'b1;
    rst_pat[1] = 1'b1;
    run(2);
    clear_pats();
  endtask

  task automatic clear_exp();
    for (int i = 0; i < 2; i++)
      for (int t = 0; t < NC; t++) expv[i][t] = '0;
  endtask

  // Schedule of one run whose start is accepted at the end of cycle off.
  task automatic add_run(int i, int off);
    int lat = i + 1;
    int t = off + 1;
    for (int k = 0; k < 4; k++) begin
      if (t < NC) begin expv[i][t].rd = 1'b1; expv[i][t].addr = 8'(k); end
      if (t + lat < NC) expv[i][t+lat].we = 4'b1000 >> k;
      t++;
    end
    t += lat;
    for (int p = 0; p < 4; p++) begin
      for (int k = 0; k < 4; k++) begin
        if (t < NC) begin
          expv[i][t].rd   = 1'b1;
          expv[i][t].addr = 8'(4 + (p / 2 + k / 2) * 3 + p % 2 + k % 2);
          expv[i][t].sel  = 8'(p * 85);
        end
        if (t + lat < NC) expv[i][t+lat].fe = 4'b1000 >> k;
        t++;
      end
      for (int w = 0; w <= lat; w++) begin
        if (t < NC) expv[i][t].sel = 8'(p * 85);
        t++;
      end
      if (t - 1 < NC) expv[i][t-1].acc = 4'b1000 >> p;
    end
    if (t < NC) expv[i][t].done = 1'b1;
    for (int u = off + 1; u <= t && u < NC; u++) expv[i][u].busy = 1'b1;
  endtask

  task automatic check_trace(string nm, int n);
    for (int i = 0; i < 2; i++)
      for (int t = 0; t < n; t++)
        chk($sformatf("%s_L%0d_cyc%0d", nm, i + 1, t), 32'(obs[i][t]), 32'(expv[i][t]));
  endtask

  task automatic check_results(string nm);
    int cv[4];
    for (int p = 0; p < 4; p++) begin
      cv[p] = 0;
      for (int k = 0; k < 4; k++)
        cv[p] += int'(mem[k]) * int'(mem[4 + (p / 2 + k / 2) * 3 + p % 2 + k % 2]);
    end
    for (int i = 0; i < 2; i++) begin
      chk($sformatf("%s_L%0d_done_cnt", nm, i + 1), 32'(done_cnt[i]), 32'd1);
      for (int p = 0; p < 4; p++)
        chk($sformatf("%s_L%0d_c%0d", nm, i + 1, p), cdone[i][p], 32'(cv[p]));
    end
  endtask

  function automatic vec_t mk(int c, logic r, logic [7:0] a, logic [3:0] w,
                              logic [3:0] ac, logic [7:0] s, logic b, logic d);
    vec_t v;
    v.cyc = c; v.rd = r; v.addr = a; v.we = w; v.acc = ac; v.sel = s;
    v.busy = b; v.done = d;
    return v;
  endfunction

  initial begin
    n_chk = 0;
    n_pass = 0;
    rst = 1'b1;
    start = 1'b1;
    for (int a = 0; a < 256; a++) mem[a] = 8'h00;
    for (int a = 0; a < 4; a++) mem[a] = 8'(a + 1);
    for (int a = 0; a < 9; a++) mem[4 + a] = 8'(a + 1);

    // Expected MEM_LAT=1 trace points (start accepted at end of cycle 0).
    tbl.push_back(mk( 0, 0, 0, 4'b0000, 4'b0000, 8'h00, 0, 0));
    tbl.push_back(mk( 1, 1, 0, 4'b0000, 4'b0000, 8'h00, 1, 0));
    tbl.push_back(mk( 2, 1, 1, 4'b1000, 4'b0000, 8'h00, 1, 0));
    tbl.push_back(mk( 3, 1, 2, 4'b0100, 4'b0000, 8'h00, 1, 0));
    tbl.push_back(mk( 4, 1, 3, 4'b0010, 4'b0000, 8'h00, 1, 0));
    tbl.push_back(mk( 5, 0, 0, 4'b0001, 4'b0000, 8'h00, 1, 0));
    tbl.push_back(mk( 6, 1, 4, 4'b0000, 4'b0000, 8'h00, 1, 0));
    tbl.push_back(mk( 7, 1, 5, 4'b0000, 4'b0000, 8'h00, 1, 0));
    tbl.push_back(mk( 8, 1, 7, 4'b0000, 4'b0000, 8'h00, 1, 0));
    tbl.push_back(mk( 9, 1, 8, 4'b0000, 4'b0000, 8'h00, 1, 0));
    tbl.push_back(mk(11, 0, 0, 4'b0000, 4'b1000, 8'h00, 1, 0));
    tbl.push_back(mk(12, 1, 5, 4'b0000, 4'b0000, 8'h55, 1, 0));
    tbl.push_back(mk(13, 1, 6, 4'b0000, 4'b0000, 8'h55, 1, 0));
    tbl.push_back(mk(14, 1, 8, 4'b0000, 4'b0000, 8'h55, 1, 0));
    tbl.push_back(mk(15, 1, 9, 4'b0000, 4'b0000, 8'h55, 1, 0));
    tbl.push_back(mk(17, 0, 0, 4'b0000, 4'b0100, 8'h55, 1, 0));
    tbl.push_back(mk(18, 1, 7, 4'b0000, 4'b0000, 8'hAA, 1, 0));
    tbl.push_back(mk(19, 1, 8, 4'b0000, 4'b0000, 8'hAA, 1, 0));
    tbl.push_back(mk(20, 1, 10, 4'b0000, 4'b0000, 8'hAA, 1, 0));
    tbl.push_back(mk(21, 1, 11, 4'b0000, 4'b0000, 8'hAA, 1, 0));
    tbl.push_back(mk(23, 0, 0, 4'b0000, 4'b0010, 8'hAA, 1, 0));
    tbl.push_back(mk(24, 1, 8, 4'b0000, 4'b0000, 8'hFF, 1, 0));
    tbl.push_back(mk(25, 1, 9, 4'b0000, 4'b0000, 8'hFF, 1, 0));
    tbl.push_back(mk(26, 1, 11, 4'b0000, 4'b0000, 8'hFF, 1, 0));
    tbl.push_back(mk(27, 1, 12, 4'b0000, 4'b0000, 8'hFF, 1, 0));
    tbl.push_back(mk(29, 0, 0, 4'b0000, 4'b0001, 8'hFF, 1, 0));
    tbl.push_back(mk(30, 0, 0, 4'b0000, 4'b0000, 8'h00, 1, 1));
    tbl.push_back(mk(31, 0, 0, 4'b0000, 4'b0000, 8'h00, 0, 0));

    @(posedge clk);

    // Reset held with start high: everything quiet.
    clear_pats();
    for (int t = 0; t < 3; t++) begin rst_pat[t] = 1'b1; start_pat[t] = 1'b1; end
    run(3);
    clear_exp();
    check_trace("reset", 3);

    // Directed run with start pulses at 5 and 30 that must be ignored.
    clear_pats();
    start_pat[0] = 1'b1;
    start_pat[5] = 1'b1;
    start_pat[30] = 1'b1;
    run(45);
    foreach (tbl[n]) begin
      ob_t o;
      o = obs[0][tbl[n].cyc];
      chk($sformatf("tbl_cyc%0d", tbl[n].cyc),
          32'({o.rd, o.addr, o.we, o.acc, o.sel, o.busy, o.done}),
          32'({tbl[n].rd, tbl[n].addr, tbl[n].we, tbl[n].acc, tbl[n].sel,
               tbl[n].busy, tbl[n].done}));
    end
    clear_exp();
    add_run(0, 0);
    add_run(1, 0);
    check_trace("single", 45);
    chk("c11_fixed", cdone[0][0], 32'd37);
    chk("c12_fixed", cdone[0][1], 32'd47);
    chk("c21_fixed", cdone[0][2], 32'd67);
    chk("c22_fixed", cdone[0][3], 32'd77);
    check_results("fixed");

    // Start held high: back-to-back identical runs.
    do_reset();
    for (int t = 0; t < 100; t++) start_pat[t] = 1'b1;
    run(100);
    clear_exp();
    for (int o = 0; o < 100; o += 31) add_run(0, o);
    for (int o = 0; o < 100; o += 36) add_run(1, o);
    check_trace("held", 100);

    // Reset asserted during cycle 15 aborts both runs.
    do_reset();
    start_pat[0] = 1'b1;
    rst_pat[15] = 1'b1;
    run(45);
    clear_exp();
    add_run(0, 0);
    add_run(1, 0);
    for (int i = 0; i < 2; i++)
      for (int t = 16; t < NC; t++) expv[i][t] = '0;
    check_trace("abort", 45);
    chk("abort_done_L1", 32'(done_cnt[0]), 32'd0);
    chk("abort_done_L2", 32'(done_cnt[1]), 32'd0);

    // Random memory contents and start noise while busy.
    for (int it = 0; it < 3; it++) begin
      for (int a = 0; a < 13; a++) mem[a] = 8'($urandom_range(0, 255));
      do_reset();
      start_pat[0] = 1'b1;
      for (int t = 1; t < 30; t++) start_pat[t] = 1'($urandom_range(0, 1));
      run(45);
      clear_exp();
      add_run(0, 0);
      add_run(1, 0);
      check_trace($sformatf("rand%0d", it), 45);
      check_results($sformatf("rand%0d", it));
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
